// File: rtl/int_arbiter.sv
// Interrupt arbiter/sequencer: latches source edges as pending, masks, picks one winner
// and runs a single non-nested service. Define IRQ_ROUND_ROBIN_EN for round-robin arbitration.
module int_arbiter #(
  parameter int                NSRC       = 4,
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 10'h3C0,
  parameter int                VEC_STRIDE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   irq_in,
  input  logic              mask_we,
  input  logic [NSRC-1:0]   mask_in,
  input  logic              int_take,
  input  logic [ADDR_W-1:0] ret_dir,
  input  logic              s_finish_interr,
  output logic              s_interruption,
  output logic [ADDR_W-1:0] int_vector,
  output logic [1:0]        int_id,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              in_service,
  output logic [NSRC-1:0]   pending,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [NSRC-1:0]   irq_q, mask, eligible, rise, take_clr;
  logic              do_arb, do_take, do_finish;
  logic [1:0]        win_id;
  logic [ADDR_W-1:0] win_vec;

  assign rise      = irq_in & ~irq_q;
  assign eligible  = pending & mask;
  assign take_clr  = do_take ? ({{(NSRC-1){1'b0}}, 1'b1} << int_id) : '0;
  assign win_vec   = VEC_BASE + ADDR_W'(VEC_STRIDE) * ADDR_W'(win_id);
  assign fsm_state = state;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;

  // Walk from the lowest-priority slot (rr_ptr itself) down to rr_ptr+1 so the last hit wins.
  always_comb begin
    logic [1:0] idx;
    win_id = '0;
    for (int k = NSRC; k >= 1; k--) begin
      idx = rr_ptr + 2'(k);
      if (eligible[idx]) win_id = idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       rr_ptr <= '0;
    else if (do_take) rr_ptr <= int_id;
  end
`else
  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 2'(i);
    end
  end
`endif

  // Handshake: s_interruption is a registered valid that stays high in REQ until the
  // control unit answers with int_take (the ready); the transfer happens on that edge.
  always_comb begin
    state_nxt = state;
    do_arb    = 1'b0;
    do_take   = 1'b0;
    do_finish = 1'b0;
    case (state)
      IDLE: if (|eligible) begin
        do_arb    = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (int_take) begin
        do_take   = 1'b1;
        state_nxt = SERVICE;
      end
      SERVICE: if (s_finish_interr) begin
        do_finish = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q          <= '0;
      pending        <= '0;
      mask           <= '1;
      int_id         <= '0;
      int_vector     <= '0;
      ret_addr       <= '0;
      s_interruption <= 1'b0;
      in_service     <= 1'b0;
    end else begin
      irq_q   <= irq_in;
      // A fresh edge on the source being cleared keeps it pending.
      pending <= (pending & ~take_clr) | rise;
      if (mask_we) mask <= mask_in;
      if (do_arb) begin
        int_id         <= win_id;
        int_vector     <= win_vec;
        s_interruption <= 1'b1;
      end
      if (do_take) begin
        ret_addr       <= ret_dir;
        s_interruption <= 1'b0;
        in_service     <= 1'b1;
      end
      if (do_finish) in_service <= 1'b0;
    end
  end

endmodule
